alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and opcode width at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_op  input  4  requester 0 opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  SHALL mirror REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_id  output  1  requester index owning the response.
REQ-012 rsp_result  output  32  ALU result.
REQ-013 rsp_zero  output  1  high when rsp_result == 0.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL contain exactly one ALU datapath shared by both requesters, time-multiplexed by a 3-state FSM: IDLE, EXEC, RESP.
REQ-016 ALU opcodes SHALL be: 0000 a+b; 0010 a-b; 0100 logical AND (1 if a!=0 and b!=0, else 0); 0101 logical OR (1 if a!=0 or b!=0); 0110 a^b; 0111 ~(a|b); 1010 unsigned a>b (1/0); any other opcode result 0.
REQ-017 Add/sub SHALL wrap modulo 2^32 with no carry or overflow output.
REQ-018 rsp_zero SHALL be computed from the registered result, including the 1 for undefined opcodes.
REQ-019 In IDLE, arbitration SHALL be round-robin via 1-bit pointer prio: when both valid, grant requester prio; when one valid, grant it.
REQ-020 reqN_ready SHALL be asserted combinationally only in IDLE, only for the granted requester, and only while its valid is high; never both at once.
REQ-021 On a handshake (valid & ready) the block SHALL latch a, b, op, and requester index, then go to EXEC.
REQ-022 In EXEC the ALU SHALL operate on latched operands only; result, zero, and id SHALL be registered at the end of EXEC; next state RESP.
REQ-023 In RESP rsp_valid SHALL be 1, and rsp_id/rsp_result/rsp_zero SHALL stay stable until rsp_ready is sampled high.
REQ-024 On rsp handshake the block SHALL return to IDLE and set prio to the complement of the served index.
REQ-025 prio SHALL change only on rsp handshake.
REQ-026 Latency: request accepted at edge N, rsp_valid high from cycle N+2; minimum spacing between accepts 3 cycles.
REQ-027 Requester inputs changing while not in IDLE SHALL have no effect on the in-flight operation.
REQ-028 A request whose valid drops before acceptance SHALL be ignored, with no state change.
REQ-029 rsp_valid and reqN_ready SHALL never be high in the same cycle.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, prio 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, busy 0, and both readys 0 (held low while rst_n is low).
REQ-031 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is produced for it after reset release.

Verification
REQ-032 Single op: req0 a=5,b=3,op=0000 -> req0_ready in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, result=8, zero=0.
REQ-033 Contention: both valid from reset, req0 op=0010 a=b=7, req1 op=1010 a=2,b=1 -> req0 served first (result 0, zero=1), then req1 (result 1, id=1); next contention grants req0 again.
REQ-034 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_* stable all 5 cycles, both readys low, busy=1; state returns to IDLE on the cycle after rsp_ready rises.
REQ-035 Edge ops: a=32'hFFFFFFFF,b=1,op=0000 -> result 0, zero=1; op=0100 a=2,b=4 -> result 1; op=0011 -> result 0, zero=1.
REQ-036 Reset mid-op: assert rst_n low during EXEC -> outputs at reset values immediately; after release with no valids, rsp_valid stays 0.
REQ-037 Input isolation: change req0_a during EXEC -> response reflects the operands latched at acceptance.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one 32-bit ALU.
// Round-robin grant in IDLE, one cycle of execute, then a held response until consumed.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        busy
);

    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           prio_q, prio_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic           id_q, id_d;
    logic           rsp_id_q, rsp_id_d;
    logic [DW-1:0]  rsp_result_q, rsp_result_d;
    logic           rsp_zero_q, rsp_zero_d;

    logic           gnt_id;
    logic           accept;
    logic [DW-1:0]  alu_result;

    // Grant: pointer breaks ties, otherwise whichever requester is valid.
    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = rst_n && (state_q == IDLE) && req0_valid && !gnt_id;
        req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  gnt_id;
        accept     = req0_ready || req1_ready;
    end

    // Shared ALU, fed only from the latched operands.
    always_comb begin
        alu_result = '0;
        unique case (op_q)
            4'b0000: alu_result = DW'(a_q + b_q);
            4'b0010: alu_result = DW'(a_q - b_q);
            4'b0100: alu_result = DW'((a_q != '0) && (b_q != '0));
            4'b0101: alu_result = DW'((a_q != '0) || (b_q != '0));
            4'b0110: alu_result = a_q ^ b_q;
            4'b0111: alu_result = ~(a_q | b_q);
            4'b1010: alu_result = DW'(a_q > b_q);
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = gnt_id ? req1_a  : req0_a;
                    b_d     = gnt_id ? req1_b  : req0_b;
                    op_d    = gnt_id ? req1_op : req0_op;
                    id_d    = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = (alu_result == '0);
                rsp_id_d     = id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    prio_d  = !rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [31:0] rsp_result;

    int checks   = 0;
    int failures = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd2:    return a - b;
            4'd4:    return (a != 0 && b != 0) ? 32'd1 : 32'd0;
            4'd5:    return (a != 0 || b != 0) ? 32'd1 : 32'd0;
            4'd6:    return a ^ b;
            4'd7:    return ~(a | b);
            4'd10:   return (a > b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: one outstanding op, its age in cycles, and the tie-break pointer.
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    bit          m_prio = 1'b0;
    bit          m_id   = 1'b0;
    logic [31:0] m_res  = '0;
    bit          er0, er1, ersp;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_req0_ready", 32'(req0_ready), 0);
            check("rst_req1_ready", 32'(req1_ready), 0);
            check("rst_rsp_id", 32'(rsp_id), 0);
            check("rst_rsp_result", rsp_result, 0);
            check("rst_rsp_zero", 32'(rsp_zero), 0);
            m_busy = 1'b0;
            m_prio = 1'b0;
        end else begin
            er0  = !m_busy && req0_valid && (!req1_valid || !m_prio);
            er1  = !m_busy && req1_valid && (!req0_valid ||  m_prio);
            ersp = m_busy && (m_age >= 1);
            check("req0_ready", 32'(req0_ready), 32'(er0));
            check("req1_ready", 32'(req1_ready), 32'(er1));
            check("busy", 32'(busy), 32'(m_busy));
            check("rsp_valid", 32'(rsp_valid), 32'(ersp));
            if (ersp) begin
                check("rsp_id", 32'(rsp_id), 32'(m_id));
                check("rsp_result", rsp_result, m_res);
                check("rsp_zero", 32'(rsp_zero), 32'(m_res == 0));
            end
            if (m_busy) begin
                if (ersp && rsp_ready) begin
                    m_busy = 1'b0;
                    m_prio = !m_id;
                end else begin
                    m_age++;
                end
            end else if (er0 || er1) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = er1;
                m_res  = er1 ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
            end
        end
    end

    task automatic set_req(input bit id, input bit v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic wait_rsp(input int max_cyc, output int n);
        n = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            n = i + 1;
            if (rsp_valid) break;
        end
        check("rsp_arrival", 32'(rsp_valid), 1);
    endtask

    // One operation from one requester; operands are scrambled right after acceptance.
    task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] exp_res, input bit exp_zero);
        int n;
        bit rdy;
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b, op);
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = id ? req1_ready : req0_ready;
        end
        check("accept", 32'(rdy), 1);
        @(posedge clk); #1;
        set_req(id, 1'b0, $urandom, $urandom, 4'($urandom));
        wait_rsp(10, n);
        check("latency", 32'(n), 2);
        check("op_id", 32'(rsp_id), 32'(id));
        check("op_result", rsp_result, exp_res);
        check("op_zero", 32'(rsp_zero), 32'(exp_zero));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 0, 0, 0);
        set_req(1'b1, 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single op and edge-case operations
        do_op(1'b0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 1'b1);
        do_op(1'b1, 32'd2, 32'd4, 4'b0100, 32'd1, 1'b0);
        do_op(1'b0, 32'd9, 32'd9, 4'b0011, 32'd0, 1'b1);
        do_op(1'b1, 32'd1, 32'd5, 4'b0010, 32'hFFFF_FFFC, 1'b0);
        do_op(1'b0, 32'd100, 32'd23, 4'b0010, 32'd77, 1'b0);

        // Contention starting out of reset
        @(posedge clk); #1 rst_n = 1'b0;
        set_req(1'b0, 1'b1, 32'd7, 32'd7, 4'b0010);
        set_req(1'b1, 1'b1, 32'd2, 32'd1, 4'b1010);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_rsp(10, n);
        check("cont1_id", 32'(rsp_id), 0);
        check("cont1_result", rsp_result, 0);
        check("cont1_zero", 32'(rsp_zero), 1);
        wait_rsp(10, n);
        check("cont2_id", 32'(rsp_id), 1);
        check("cont2_result", rsp_result, 1);
        wait_rsp(10, n);
        check("cont3_id", 32'(rsp_id), 0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 0, 0, 0);
        set_req(1'b1, 1'b0, 0, 0, 0);

        // Backpressure with a competing request waiting
        rsp_ready = 1'b0;
        @(posedge clk); #1 set_req(1'b1, 1'b1, 32'd9, 32'd4, 4'b0010);
        wait_rsp(10, n);
        check("bp_result", rsp_result, 32'd5);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            set_req(1'b1, 1'b0, 0, 0, 0);
            set_req(1'b0, 1'b1, 32'd6, 32'd6, 4'b0110);
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_hold_result", rsp_result, 32'd5);
            check("bp_hold_id", 32'(rsp_id), 1);
            check("bp_busy", 32'(busy), 1);
            check("bp_req0_ready", 32'(req0_ready), 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 1);
        @(negedge clk);
        check("bp_idle_busy", 32'(busy), 0);
        check("bp_idle_rsp", 32'(rsp_valid), 0);
        check("bp_idle_grant", 32'(req0_ready), 1);
        @(posedge clk); #1 set_req(1'b0, 1'b0, 0, 0, 0);
        wait_rsp(10, n);
        check("bp_next_zero", 32'(rsp_zero), 1);

        // Reset while executing
        @(posedge clk); #1 set_req(1'b0, 1'b1, 32'd5, 32'd6, 4'b0000);
        @(negedge clk);
        check("rm_accept", 32'(req0_ready), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("rm_rsp_valid", 32'(rsp_valid), 0);
        check("rm_busy", 32'(busy), 0);
        check("rm_req0_ready", 32'(req0_ready), 0);
        check("rm_zero", 32'(rsp_zero), 0);
        check("rm_result", rsp_result, 0);
        set_req(1'b0, 1'b0, 0, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rm_no_rsp", 32'(rsp_valid), 0);
        end

        // Randomized traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int r = 0; r < 2; r++) begin
                set_req(1'(r), ($urandom_range(0, 9) < 6),
                        ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom),
                        ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                        4'($urandom_range(0, 15)));
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 0, 0, 0);
        set_req(1'b1, 1'b0, 0, 0, 0);
        repeat (6) @(negedge clk);
        check("final_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
